cbm2_keyboard: RTL and testbench

- Keyboard matrix emulation feeding TPI2 in the CBM-II core.
- Consumes MiSTer HPS PS/2 key events, keeps a 16-column x 6-row key-state matrix, and returns active-low row sense (TPI2 PC0-5) for the active-low column drive (TPI2 PA/PB outputs).
- Sits directly upstream of tpi2 `pc_in[5:0]`; PC6/PC7 stay tied high at the instantiation.

---
 rtl/cbm2_kbd_pkg.sv | 54 +++++
 rtl/cbm2_kbd_map.sv | 47 ++++
 rtl/cbm2_keyboard.sv | 189 ++++++++++++++++++
 tb/tb_cbm2_keyboard.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbm2_kbd_pkg.sv
// CBM-II keyboard matrix: shared types, sizes and named key positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cbm2_kbd_pkg;

    localparam int KBD_COLS = 16;
    localparam int KBD_ROWS = 6;

    // Result of a scancode lookup: where the key lives in the matrix.
    typedef struct packed {
        logic       valid;
        logic [3:0] col;
        logic [2:0] row;
    } kbd_pos_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_APPLY
    } kbd_state_t;

    function automatic kbd_pos_t kpos(input logic [3:0] col, input logic [2:0] row);
        kbd_pos_t p;
        p.valid = 1'b1;
        p.col   = col;
        p.row   = row;
        return p;
    endfunction

    // Column 0-7 is driven by TPI2 PB0-7, column 8-15 by PA0-7.
    localparam kbd_pos_t KEY_ESC         = kpos(4'd0,  3'd1);
    localparam kbd_pos_t KEY_1           = kpos(4'd2,  3'd0);
    localparam kbd_pos_t KEY_2           = kpos(4'd3,  3'd0);
    localparam kbd_pos_t KEY_A           = kpos(4'd2,  3'd1);
    localparam kbd_pos_t KEY_S           = kpos(4'd3,  3'd1);
    localparam kbd_pos_t KEY_D           = kpos(4'd4,  3'd1);
    localparam kbd_pos_t KEY_Q           = kpos(4'd2,  3'd2);
    localparam kbd_pos_t KEY_W           = kpos(4'd3,  3'd2);
    localparam kbd_pos_t KEY_E           = kpos(4'd4,  3'd2);
    localparam kbd_pos_t KEY_Z           = kpos(4'd2,  3'd3);
    localparam kbd_pos_t KEY_X           = kpos(4'd3,  3'd3);
    localparam kbd_pos_t KEY_SPACE       = kpos(4'd6,  3'd5);
    localparam kbd_pos_t KEY_LSHIFT      = kpos(4'd8,  3'd4);
    localparam kbd_pos_t KEY_CTRL        = kpos(4'd8,  3'd5);
    localparam kbd_pos_t KEY_RETURN      = kpos(4'd10, 3'd3);
    localparam kbd_pos_t KEY_RSHIFT      = kpos(4'd11, 3'd4);
    localparam kbd_pos_t KEY_DEL         = kpos(4'd12, 3'd0);
    localparam kbd_pos_t KEY_KP8         = kpos(4'd13, 3'd2);
    localparam kbd_pos_t KEY_CRSR_UP     = kpos(4'd14, 3'd0);
    localparam kbd_pos_t KEY_CRSR_DOWN   = kpos(4'd14, 3'd1);
    localparam kbd_pos_t KEY_CRSR_LEFT   = kpos(4'd15, 3'd0);
    localparam kbd_pos_t KEY_CRSR_RIGHT  = kpos(4'd15, 3'd1);

endpackage

// File: rtl/cbm2_kbd_map.sv
// PS/2 set-2 scancode {ext, code} to CBM-II matrix position ROM.
// Latency: 1 cycle, registered output; unmapped codes give valid=0.
// Backpressure: none, a new lookup is accepted every cycle.
module cbm2_kbd_map
    import cbm2_kbd_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ext,
    input  logic [7:0] code,
    output kbd_pos_t   pos
);

    // Registered case-ROM; anything not listed resolves to an invalid position.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos <= '0;
        end else begin
            case ({ext, code})
                9'h076:  pos <= KEY_ESC;
                9'h016:  pos <= KEY_1;
                9'h01E:  pos <= KEY_2;
                9'h01C:  pos <= KEY_A;
                9'h01B:  pos <= KEY_S;
                9'h023:  pos <= KEY_D;
                9'h015:  pos <= KEY_Q;
                9'h01D:  pos <= KEY_W;
                9'h024:  pos <= KEY_E;
                9'h01A:  pos <= KEY_Z;
                9'h022:  pos <= KEY_X;
                9'h029:  pos <= KEY_SPACE;
                9'h012:  pos <= KEY_LSHIFT;
                9'h014:  pos <= KEY_CTRL;
                9'h05A:  pos <= KEY_RETURN;
                9'h059:  pos <= KEY_RSHIFT;
                9'h066:  pos <= KEY_DEL;
                9'h075:  pos <= KEY_KP8;
                9'h175:  pos <= KEY_CRSR_UP;
                9'h172:  pos <= KEY_CRSR_DOWN;
                9'h16B:  pos <= KEY_CRSR_LEFT;
                9'h174:  pos <= KEY_CRSR_RIGHT;
                default: pos <= '0;
            endcase
        end
    end

endmodule

// File: rtl/cbm2_keyboard.sv
// CBM-II keyboard matrix emulation: PS/2 events -> 16x6 key matrix -> TPI2 row sense.
// Latency: event capture to row_n is 4 cycles (5 with CBM2_KBD_GHOST_EN); col_n to row_n 1 cycle (2).
// Backpressure: none; one pending event slot, newer event overwrites and sets sticky key_ovf.
module cbm2_keyboard
    import cbm2_kbd_pkg::*;
#(
    parameter int ROWS = KBD_ROWS,
    parameter int COLS = KBD_COLS
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [10:0]     ps2_key,
    input  logic [COLS-1:0] col_n,
    output logic [ROWS-1:0] row_n,
    output logic            key_ovf,
    output logic            busy
);

    logic                       tog_q;
    logic                       evt;
    logic                       pend_v;
    logic                       pend_make;
    logic                       pend_ext;
    logic [7:0]                 pend_code;
    logic                       work_make;
    logic                       work_ext;
    logic [7:0]                 work_code;
    kbd_state_t                 state_q;
    kbd_state_t                 state_d;
    logic                       take;
    logic                       apply;
    kbd_pos_t                   map_pos;
    logic [COLS-1:0][ROWS-1:0]  matrix;
    logic [ROWS-1:0]            hit;

    assign evt  = ps2_key[10] ^ tog_q;
    assign busy = (state_q != ST_IDLE);

    // Toggle tracking and the single pending-event slot; a fresh event always wins.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q     <= ps2_key[10];
            pend_v    <= 1'b0;
            pend_make <= 1'b0;
            pend_ext  <= 1'b0;
            pend_code <= '0;
            key_ovf   <= 1'b0;
        end else begin
            tog_q <= ps2_key[10];
            if (evt) begin
                pend_v    <= 1'b1;
                pend_make <= ps2_key[9];
                pend_ext  <= ps2_key[8];
                pend_code <= ps2_key[7:0];
                // Overwriting is only a loss when the FSM is not consuming the slot now.
                if (pend_v && !take) begin
                    key_ovf <= 1'b1;
                end
            end else if (take) begin
                pend_v <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and strobes: IDLE -> LOOKUP -> APPLY, one cycle each.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_v) begin
                    take    = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_APPLY;
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Work register holds the event being processed while the slot refills.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            work_make <= 1'b0;
            work_ext  <= 1'b0;
            work_code <= '0;
        end else if (take) begin
            work_make <= pend_make;
            work_ext  <= pend_ext;
            work_code <= pend_code;
        end
    end

    cbm2_kbd_map u_map (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ext     (work_ext),
        .code    (work_code),
        .pos     (map_pos)
    );

    // Matrix write: make presses, break releases; repeats are naturally idempotent.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            matrix <= '0;
        end else if (apply && map_pos.valid) begin
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (map_pos.col == c[3:0] && map_pos.row == r[2:0]) begin
                        matrix[c][r] <= work_make;
                    end
                end
            end
        end
    end

`ifdef CBM2_KBD_GHOST_EN
    logic [ROWS-1:0] sel_rows;
    logic [COLS-1:0] effcol;
    logic [ROWS-1:0] hit_q;

    // One level of ghosting: a column sharing a pressed row with a driven column also conducts.
    always_comb begin
        sel_rows = '0;
        hit      = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_n[c]) begin
                sel_rows = sel_rows | matrix[c];
            end
        end
        effcol = ~col_n;
        for (int c = 0; c < COLS; c++) begin
            if (|(matrix[c] & sel_rows)) begin
                effcol[c] = 1'b1;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (effcol[c]) begin
                hit = hit | matrix[c];
            end
        end
    end

    // Two-stage row sense so the wider ghost cone has a full cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hit_q <= '0;
            row_n <= '1;
        end else begin
            hit_q <= hit;
            row_n <= ~hit_q;
        end
    end
`else
    // Ideal matrix: a row reads low if any driven column has that key pressed.
    always_comb begin
        hit = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_n[c]) begin
                hit = hit | matrix[c];
            end
        end
    end

    // Registered active-low row sense.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            row_n <= '1;
        end else begin
            row_n <= ~hit;
        end
    end
`endif

endmodule

// File: tb/tb_cbm2_keyboard.sv
// Self-checking bench for cbm2_keyboard against a table-driven key-state model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cbm2_keyboard;

`ifdef CBM2_KBD_GHOST_EN
    localparam int LAT = 5;
    localparam bit GHOST = 1'b1;
`else
    localparam int LAT = 4;
    localparam bit GHOST = 1'b0;
`endif

    localparam int NT = 22;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] col_n;
    logic [5:0]  row_n;
    logic        key_ovf;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference key table: {ext, code} -> (column, row).
    logic [8:0] t_key[NT] = '{9'h076, 9'h016, 9'h01E, 9'h01C, 9'h01B, 9'h023, 9'h015, 9'h01D,
                              9'h024, 9'h01A, 9'h022, 9'h029, 9'h012, 9'h014, 9'h05A, 9'h059,
                              9'h066, 9'h075, 9'h175, 9'h172, 9'h16B, 9'h174};
    int t_col[NT] = '{0, 2, 3, 2, 3, 4, 2, 3, 4, 2, 3, 6, 8, 8, 10, 11, 12, 13, 14, 14, 15, 15};
    int t_row[NT] = '{1, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 5, 4, 5, 3, 4, 0, 2, 0, 1, 0, 1};

    bit mm[16][6];

    cbm2_keyboard dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .col_n   (col_n),
        .row_n   (row_n),
        .key_ovf (key_ovf),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic int find(input logic [8:0] key);
        for (int i = 0; i < NT; i++) begin
            if (t_key[i] == key) return i;
        end
        return -1;
    endfunction

    function automatic logic [5:0] expect_rows(input logic [15:0] cn);
        bit          eff[16];
        logic [5:0]  r;
        for (int c = 0; c < 16; c++) eff[c] = !cn[c];
        if (GHOST) begin
            for (int c = 0; c < 16; c++)
                for (int c2 = 0; c2 < 16; c2++)
                    for (int k = 0; k < 6; k++)
                        if (!cn[c2] && mm[c][k] && mm[c2][k]) eff[c] = 1'b1;
        end
        r = 6'h3F;
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 6; k++)
                if (eff[c] && mm[c][k]) r[k] = 1'b0;
        return r;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < 16; c++)
            for (int k = 0; k < 6; k++)
                mm[c][k] = 1'b0;
    endtask

    // Flip the strobe; optionally record the expected matrix effect.
    task automatic send(input bit make, input bit ext, input logic [7:0] code, input bit upd);
        int i;
        ps2_key = {~ps2_key[10], make, ext, code};
        i = find({ext, code});
        if (upd && i >= 0) mm[t_col[i]][t_row[i]] = make;
    endtask

    task automatic send_wait(input bit make, input bit ext, input logic [7:0] code);
        send(make, ext, code, 1'b1);
        repeat (LAT + 3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
        tick();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        ps2_key = 11'h000;
        col_n   = 16'hFFFF;
        tick();
        // stale strobe high while in reset must not produce an event afterwards
        ps2_key = 11'h61C;
        tick();
        reset = 1'b0;
        clear_model();
        tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL reset_row_n actual=%h required=3f", row_n); end
        total++; if (key_ovf !== 1'b0) begin bad++; $display("FAIL reset_key_ovf actual=%b required=0", key_ovf); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
        col_n = 16'hFFFB;
        repeat (LAT + 3) tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stale_toggle_busy actual=%b required=0", busy); end
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL stale_toggle_row actual=%h required=3f", row_n); end
    endtask

    task automatic test_latency();
        col_n = ~(16'h0001 << 2);
        tick();
        tick();
        send(1'b1, 1'b0, 8'h1C, 1'b1);
        tick();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_during_lookup actual=%b required=1", busy); end
        repeat (LAT - 2) tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL lat_early actual=%h required=3f", row_n); end
        tick();
        total++; if (row_n !== 6'h3D) begin bad++; $display("FAIL lat_make actual=%h required=3d", row_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_after actual=%b required=0", busy); end
        send(1'b1, 1'b0, 8'h1C, 1'b1);
        repeat (LAT + 3) tick();
        total++; if (row_n !== 6'h3D) begin bad++; $display("FAIL repeat_make actual=%h required=3d", row_n); end
        send(1'b0, 1'b0, 8'h1C, 1'b1);
        repeat (LAT + 1) tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL lat_break actual=%h required=3f", row_n); end
        send_wait(1'b0, 1'b0, 8'h1C);
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL break_unpressed actual=%h required=3f", row_n); end
    endtask

    task automatic test_ext();
        col_n = ~(16'h0001 << 14);
        send_wait(1'b1, 1'b1, 8'h75);
        total++; if (row_n !== 6'h3E) begin bad++; $display("FAIL ext_crsr_up actual=%h required=3e", row_n); end
        send_wait(1'b1, 1'b0, 8'h75);
        total++; if (row_n !== 6'h3E) begin bad++; $display("FAIL plain75_col14 actual=%h required=3e", row_n); end
        col_n = ~(16'h0001 << 13);
        repeat (3) tick();
        total++; if (row_n !== 6'h3B) begin bad++; $display("FAIL plain75_col13 actual=%h required=3b", row_n); end
        send_wait(1'b1, 1'b1, 8'h1C);
        col_n = 16'h0000;
        repeat (3) tick();
        total++; if (row_n !== expect_rows(col_n)) begin bad++; $display("FAIL ext_unmapped actual=%h required=%h", row_n, expect_rows(col_n)); end
        send_wait(1'b0, 1'b1, 8'h75);
        send_wait(1'b0, 1'b0, 8'h75);
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL ext_release actual=%h required=3f", row_n); end
    endtask

    task automatic test_random();
        logic [8:0]  key;
        logic [15:0] cn;
        bit          mk;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) key = t_key[$urandom_range(0, NT - 1)];
            else key = 9'($urandom);
            mk = 1'($urandom_range(0, 1));
            send(mk, key[8], key[7:0], 1'b1);
            repeat (LAT + 2) tick();
            case ($urandom_range(0, 5))
                0: cn = 16'hFFFF;
                1: cn = 16'h0000;
                2: cn = ~(16'h0001 << $urandom_range(0, 15));
                default: cn = 16'($urandom);
            endcase
            col_n = cn;
            repeat (3) tick();
            total++; if (row_n !== expect_rows(cn)) begin bad++; $display("FAIL random_rows n=%0d col_n=%h actual=%h required=%h", n, cn, row_n, expect_rows(cn)); end
        end
        total++; if (key_ovf !== 1'b0) begin bad++; $display("FAIL random_no_ovf actual=%b required=0", key_ovf); end
    endtask

    task automatic test_overflow();
        do_reset();
        // Q, W, E strobes on consecutive cycles: Q and E land, W is overwritten.
        send(1'b1, 1'b0, 8'h15, 1'b1);
        tick();
        send(1'b1, 1'b0, 8'h1D, 1'b0);
        tick();
        send(1'b1, 1'b0, 8'h24, 1'b1);
        repeat (2 * LAT + 4) tick();
        total++; if (key_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set actual=%b required=1", key_ovf); end
        col_n = ~(16'h0001 << 3);
        repeat (3) tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL ovf_lost_w actual=%h required=3f", row_n); end
        col_n = ~(16'h0001 << 2);
        repeat (3) tick();
        total++; if (row_n !== 6'h3B) begin bad++; $display("FAIL ovf_first_q actual=%h required=3b", row_n); end
        col_n = ~(16'h0001 << 4);
        repeat (3) tick();
        total++; if (row_n !== 6'h3B) begin bad++; $display("FAIL ovf_third_e actual=%h required=3b", row_n); end
        send_wait(1'b1, 1'b0, 8'h1B);
        repeat (10) tick();
        total++; if (key_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky actual=%b required=1", key_ovf); end
    endtask

    task automatic test_reset_mid();
        send_wait(1'b1, 1'b0, 8'h1C);
        send_wait(1'b1, 1'b0, 8'h5A);
        col_n = 16'h0000;
        repeat (3) tick();
        total++; if (row_n !== expect_rows(col_n)) begin bad++; $display("FAIL all_cols_model actual=%h required=%h", row_n, expect_rows(col_n)); end
        do_reset();
        send_wait(1'b1, 1'b0, 8'h1C);
        send_wait(1'b1, 1'b0, 8'h5A);
        repeat (3) tick();
        total++; if (row_n !== 6'h35) begin bad++; $display("FAIL a_return_all_cols actual=%h required=35", row_n); end
        send(1'b1, 1'b0, 8'h12, 1'b0);
        tick();
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy actual=%b required=1", busy); end
        reset = 1'b1;
        tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL mid_reset_row actual=%h required=3f", row_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy actual=%b required=0", busy); end
        total++; if (key_ovf !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf actual=%b required=0", key_ovf); end
        reset = 1'b0;
        clear_model();
        repeat (LAT + 4) tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL mid_reset_discard actual=%h required=3f", row_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_idle actual=%b required=0", busy); end
    endtask

    task automatic test_ghost();
        logic [5:0] req;
        do_reset();
        send_wait(1'b1, 1'b0, 8'h1C);
        send_wait(1'b1, 1'b0, 8'h1A);
        send_wait(1'b1, 1'b0, 8'h5A);
        col_n = ~(16'h0001 << 10);
        repeat (3) tick();
        req = GHOST ? 6'h35 : 6'h37;
        total++; if (row_n !== req) begin bad++; $display("FAIL ghost_col10 actual=%h required=%h", row_n, req); end
        total++; if (row_n !== expect_rows(col_n)) begin bad++; $display("FAIL ghost_model actual=%h required=%h", row_n, expect_rows(col_n)); end
        col_n = 16'hFFFF;
        repeat (3) tick();
        total++; if (row_n !== 6'h3F) begin bad++; $display("FAIL ghost_none_sel actual=%h required=3f", row_n); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ext();
        test_random();
        test_overflow();
        test_reset_mid();
        test_ghost();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
